// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller:
// forwarding-select encodings, wait-FSM states and the hard-wired zero register.
package pipe_ctrl_pkg;

   localparam logic [4:0] X0 = 5'd0;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/forward_unit.sv
// Combinational E-stage operand forwarding; M-stage results take priority
// over W-stage results and x0 is never forwarded.
module forward_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs1_e_i,
   input  logic [4:0] rs2_e_i,
   input  logic [4:0] rd_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       reg_write_m_i,
   input  logic       reg_write_w_i,
   output logic [1:0] forward_a_o,
   output logic [1:0] forward_b_o
);

   logic [1:0][4:0] rs_e;
   logic [1:0][1:0] fwd_sel;
   logic            m_valid;
   logic            w_valid;

   assign rs_e[0] = rs1_e_i;
   assign rs_e[1] = rs2_e_i;

   assign m_valid = reg_write_m_i && (rd_m_i != X0);
   assign w_valid = reg_write_w_i && (rd_w_i != X0);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         assign fwd_sel[gi] = (m_valid && (rs_e[gi] == rd_m_i)) ? FWD_M :
                              (w_valid && (rs_e[gi] == rd_w_i)) ? FWD_W : FWD_RF;
      end
   endgenerate

   assign forward_a_o = fwd_sel[0];
   assign forward_b_o = fwd_sel[1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stall/flush
// generation, data-memory wait FSM with timeout watchdog, and perf counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 256,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             DMemReqM,
   input  logic             DMemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemErr,
   output logic [CNT_W-1:0] LuStallCnt,
   output logic [CNT_W-1:0] MemStallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int              TO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   ctrl_state_e     state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            mem_err_q, mem_err_d;

   logic lw_stall;
   logic mem_req_new;
   logic mem_wait;
   logic timeout_hit;

   forward_unit u_forward_unit (
      .rs1_e_i       (Rs1E),
      .rs2_e_i       (Rs2E),
      .rd_m_i        (RdM),
      .rd_w_i        (RdW),
      .reg_write_m_i (RegWriteM),
      .reg_write_w_i (RegWriteW),
      .forward_a_o   (ForwardAE),
      .forward_b_o   (ForwardBE)
   );

   assign lw_stall    = ResultSrcE0 && (RdE != X0) && ((Rs1D == RdE) || (Rs2D == RdE));
   assign mem_req_new = DMemReqM && !DMemReadyM && !mem_err_q;
   assign mem_wait    = mem_req_new || ((state_q == WAIT) && !DMemReadyM);
   assign timeout_hit = (state_q == WAIT) && !DMemReadyM && (to_cnt_q == TO_LAST);

   // Ready on the timeout edge wins: the access completes and no error is raised.
   always_comb begin
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      mem_err_d = mem_err_q;
      case (state_q)
         IDLE: begin
            if (mem_req_new) begin
               state_d  = WAIT;
               to_cnt_d = '0;
            end
         end
         WAIT: begin
            if (DMemReadyM) begin
               state_d = IDLE;
            end else if (timeout_hit) begin
               state_d   = IDLE;
               mem_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         to_cnt_q  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   // A frozen branch in E must not flush while memory holds the pipe.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (!rst) begin
         StallF = 1'b0;
      end else if (mem_wait) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushD = PCSrcE;
         FlushE = lw_stall | PCSrcE;
      end
   end

   assign MemErr = mem_err_q;

   logic [2:0]            cnt_inc;
   logic [2:0][CNT_W-1:0] cnt_val;

   assign cnt_inc[0] = lw_stall && !mem_wait;
   assign cnt_inc[1] = mem_wait;
   assign cnt_inc[2] = PCSrcE && !mem_wait;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_perf_cnt
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         assign cnt_d = (cnt_inc[gi] && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign cnt_val[gi] = cnt_q;
      end
   endgenerate

   assign LuStallCnt  = cnt_val[0];
   assign MemStallCnt = cnt_val[1];
   assign FlushCnt    = cnt_val[2];

`ifndef SYNTHESIS
   a_lw_branch_excl: assert property (@(posedge clk) disable iff (!rst) !(lw_stall && PCSrcE));
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (small timeout and
// narrow counters so the watchdog and saturation paths are reachable).
module tb_pipeline_hazard_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;

   localparam logic [6:0] C_NONE = 7'b000_0000;
   localparam logic [6:0] C_LW   = 7'b110_0010;
   localparam logic [6:0] C_BR   = 7'b000_0110;
   localparam logic [6:0] C_MW   = 7'b111_1001;

   logic             clk;
   logic             rst;
   logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic             RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, DMemReqM, DMemReadyM;
   logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             MemErr;
   logic [CNT_W-1:0] LuStallCnt, MemStallCnt, FlushCnt;
   logic [6:0]       ctrl;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .RdE         (RdE),
      .RdM         (RdM),
      .RdW         (RdW),
      .RegWriteM   (RegWriteM),
      .RegWriteW   (RegWriteW),
      .ResultSrcE0 (ResultSrcE0),
      .PCSrcE      (PCSrcE),
      .DMemReqM    (DMemReqM),
      .DMemReadyM  (DMemReadyM),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushW      (FlushW),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .MemErr      (MemErr),
      .LuStallCnt  (LuStallCnt),
      .MemStallCnt (MemStallCnt),
      .FlushCnt    (FlushCnt)
   );

   assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-16s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
      DMemReqM = 0; DMemReadyM = 0;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      // Reset: controls forced low even with hazards present; forwarding stays live
      RdM = 5; RegWriteM = 1; Rs1E = 5;
      ResultSrcE0 = 1; RdE = 7; Rs2D = 7; DMemReqM = 1;
      #1;
      chk("rst_ctrl", 32'(ctrl), 32'(C_NONE));
      chk("rst_fwdA", 32'(ForwardAE), 32'h2);
      chk("rst_memerr", 32'(MemErr), 32'h0);
      chk("rst_cnts", {20'h0, LuStallCnt, MemStallCnt, FlushCnt}, 32'h0);

      @(negedge clk); clear_inputs(); rst = 1'b1;

      // Forwarding: M beats W, then W, then none, x0 never forwards
      @(negedge clk);
      Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #1;
      chk("fwdA_m_wins", 32'(ForwardAE), 32'h2);
      chk("fwdB_m_wins", 32'(ForwardBE), 32'h2);
      RdM = 0; #1;
      chk("fwdA_rdm0_w", 32'(ForwardAE), 32'h1);
      RegWriteW = 0; #1;
      chk("fwdA_none", 32'(ForwardAE), 32'h0);
      Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1; #1;
      chk("fwdA_x0", 32'(ForwardAE), 32'h0);
      Rs2E = 9; RdW = 9; RdM = 9; RegWriteM = 0; #1;
      chk("fwdB_w", 32'(ForwardBE), 32'h1);
      chk("fwd_ctrl", 32'(ctrl), 32'(C_NONE));

      // Load-use stall for one cycle
      @(negedge clk); clear_inputs();
      ResultSrcE0 = 1; RdE = 7; Rs2D = 7; #1;
      chk("lw_ctrl", 32'(ctrl), 32'(C_LW));
      @(negedge clk); clear_inputs();
      ResultSrcE0 = 1; RdE = 0; Rs1D = 0; #1;
      chk("lw_rde0_ctrl", 32'(ctrl), 32'(C_NONE));
      chk("lu_cnt1", 32'(LuStallCnt), 32'h1);
      @(negedge clk); clear_inputs(); #1;
      chk("lu_cnt_hold", 32'(LuStallCnt), 32'h1);

      // Taken branch for one cycle
      @(negedge clk); PCSrcE = 1; #1;
      chk("br_ctrl", 32'(ctrl), 32'(C_BR));
      @(negedge clk); PCSrcE = 0; #1;
      chk("br_ctrl_off", 32'(ctrl), 32'(C_NONE));
      chk("flush_cnt1", 32'(FlushCnt), 32'h1);

      // Memory wait of 3 cycles with a branch frozen in E
      @(negedge clk); DMemReqM = 1; DMemReadyM = 0; PCSrcE = 1; #1;
      chk("mw_ctrl0", 32'(ctrl), 32'(C_MW));
      @(negedge clk); #1;
      chk("mw_ctrl1", 32'(ctrl), 32'(C_MW));
      chk("mw_cnt1", 32'(MemStallCnt), 32'h1);
      @(negedge clk); #1;
      chk("mw_ctrl2", 32'(ctrl), 32'(C_MW));
      chk("mw_flushcnt", 32'(FlushCnt), 32'h1);
      @(negedge clk); DMemReadyM = 1; #1;
      chk("mw_ready_ctrl", 32'(ctrl), 32'(C_BR));
      chk("mw_cnt3", 32'(MemStallCnt), 32'h3);
      @(negedge clk); clear_inputs(); #1;
      chk("mw_cnt_final", 32'(MemStallCnt), 32'h3);
      chk("mw_flushcnt2", 32'(FlushCnt), 32'h2);

      // Asynchronous reset in the middle of a wait
      @(negedge clk); DMemReqM = 1; #1;
      chk("rw_ctrl0", 32'(ctrl), 32'(C_MW));
      @(negedge clk); #1;
      chk("rw_ctrl1", 32'(ctrl), 32'(C_MW));
      #1 rst = 1'b0; #1;
      chk("rw_ctrl_rst", 32'(ctrl), 32'(C_NONE));
      chk("rw_cnts", {20'h0, LuStallCnt, MemStallCnt, FlushCnt}, 32'h0);
      chk("rw_memerr", 32'(MemErr), 32'h0);
      @(negedge clk); clear_inputs(); rst = 1'b1; #1;
      chk("rw_idle_ctrl", 32'(ctrl), 32'(C_NONE));

      // Ready arriving on the timeout cycle wins
      @(negedge clk); DMemReqM = 1; #1;
      for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
         @(negedge clk); #1;
         chk("tr_wait_ctrl", 32'(ctrl), 32'(C_MW));
      end
      @(negedge clk); DMemReadyM = 1; #1;
      chk("tr_ready_ctrl", 32'(ctrl), 32'(C_NONE));
      @(negedge clk); clear_inputs(); #1;
      chk("tr_memerr", 32'(MemErr), 32'h0);
      chk("tr_memcnt", 32'(MemStallCnt), 32'h4);

      // Timeout: 4 WAIT cycles, then MemErr and the pipe resumes
      @(negedge clk); DMemReqM = 1; #1;
      chk("to_ctrl_idle", 32'(ctrl), 32'(C_MW));
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         @(negedge clk); #1;
         chk("to_wait_ctrl", 32'(ctrl), 32'(C_MW));
         chk("to_wait_err", 32'(MemErr), 32'h0);
      end
      @(negedge clk); #1;
      chk("to_memerr", 32'(MemErr), 32'h1);
      chk("to_ctrl_rel", 32'(ctrl), 32'(C_NONE));
      chk("to_memcnt", 32'(MemStallCnt), 32'h9);
      @(negedge clk); DMemReqM = 0; #1;
      @(negedge clk); DMemReqM = 1; #1;
      chk("to_later_ctrl", 32'(ctrl), 32'(C_NONE));
      @(negedge clk); #1;
      chk("to_err_sticky", 32'(MemErr), 32'h1);
      chk("to_memcnt_hold", 32'(MemStallCnt), 32'h9);

      // Reset clears the sticky error
      @(negedge clk); clear_inputs(); rst = 1'b0; #1;
      chk("re_memerr", 32'(MemErr), 32'h0);
      @(negedge clk); rst = 1'b1;

      // Counter saturation
      @(negedge clk); PCSrcE = 1;
      repeat (17) @(negedge clk);
      PCSrcE = 0; #1;
      chk("sat_flushcnt", 32'(FlushCnt), 32'hF);
      @(negedge clk); #1;
      chk("sat_hold", 32'(FlushCnt), 32'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
